// File: rtl/soc_ifc_fw_rst_req_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soc_ifc_fw_rst_req_arb_if : requester/boot-sequencer bundle for the fw reset arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
interface soc_ifc_fw_rst_req_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int WAIT_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*WAIT_W-1:0] req_wait_cycles;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      busy;
  logic                      fw_update_rst;
  logic [WAIT_W-1:0]         fw_update_rst_wait_cycles;
  logic                      fw_upd_rst_executed;
  logic                      cptra_uc_rst_b;

  modport master (
    output req, req_wait_cycles, fw_upd_rst_executed, cptra_uc_rst_b,
    input  grant, done, err, busy, fw_update_rst, fw_update_rst_wait_cycles
  );

  modport slave (
    input  req, req_wait_cycles, fw_upd_rst_executed, cptra_uc_rst_b,
    output grant, done, err, busy, fw_update_rst, fw_update_rst_wait_cycles
  );
endinterface
`default_nettype wire

// File: rtl/soc_ifc_fw_rst_req_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soc_ifc_fw_rst_req_arb : round-robin arbiter serialising fw-update reset requests
// Revision 1.0
// ---------------------------------------------------------------------------
module soc_ifc_fw_rst_req_arb #(
  parameter int NUM_REQ        = 3,
  parameter int WAIT_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input wire                      clk,
  input wire                      cptra_rst_b,
  soc_ifc_fw_rst_req_arb_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] ISSUE        = 3'd1;
  localparam logic [2:0] WAIT_ASSERT  = 3'd2;
  localparam logic [2:0] WAIT_RELEASE = 3'd3;
  localparam logic [2:0] DONE         = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               busy_q, busy_d;
  logic               fw_update_rst_q, fw_update_rst_d;
  logic [WAIT_W-1:0]  wait_cycles_q, wait_cycles_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0] w_arb_req;
  logic [NUM_REQ-1:0] w_arb_oh;
  logic               w_arb_valid;
  int                 w_arb_idx;
  logic               w_exit;
  logic               w_in_service;
  logic               w_tmo_hit;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic [PTR_W-1:0]   w_next_ptr;

  // A requester that just timed out is masked for one cycle so its stale level cannot re-win.
  assign w_arb_req   = bus.req & ~err_q;
  assign w_arb_valid = (|w_arb_req) && bus.cptra_uc_rst_b;

  always_comb begin
    w_arb_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_arb_req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        w_arb_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_arb_oh[i] = (w_arb_idx == i);
    end
  end

  always_comb begin
    w_exit       = 1'b0;
    w_in_service = 1'b0;
    case (state_q)
      ISSUE:        begin w_exit = bus.fw_upd_rst_executed; w_in_service = 1'b1; end
      WAIT_ASSERT:  begin w_exit = !bus.cptra_uc_rst_b;     w_in_service = 1'b1; end
      WAIT_RELEASE: begin w_exit = bus.cptra_uc_rst_b;      w_in_service = 1'b1; end
      default:      begin w_exit = 1'b0;                    w_in_service = 1'b0; end
    endcase
  end

  assign w_tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_tmo_inc  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
  assign w_next_ptr = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    done_d          = '0;
    err_d           = '0;
    fw_update_rst_d = fw_update_rst_q;
    wait_cycles_d   = wait_cycles_q;
    rr_ptr_d        = rr_ptr_q;
    win_d           = win_q;
    tmo_cnt_d       = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (w_arb_valid) begin
          state_d         = ISSUE;
          grant_d         = w_arb_oh;
          fw_update_rst_d = 1'b1;
          wait_cycles_d   = bus.req_wait_cycles[w_arb_idx*WAIT_W +: WAIT_W];
          win_d           = PTR_W'(w_arb_idx);
          tmo_cnt_d       = '0;
        end
      end
      ISSUE: begin
        if (w_exit) begin
          state_d         = WAIT_ASSERT;
          fw_update_rst_d = 1'b0;
        end
      end
      WAIT_ASSERT: begin
        if (w_exit) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (w_exit) begin
          state_d  = DONE;
          done_d   = grant_q;
          grant_d  = '0;
          rr_ptr_d = w_next_ptr;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Timeout only fires when the current state's exit is not also satisfied.
    if (w_in_service) begin
      tmo_cnt_d = w_tmo_inc;
      if (!w_exit && w_tmo_hit) begin
        state_d         = IDLE;
        err_d           = grant_q;
        grant_d         = '0;
        fw_update_rst_d = 1'b0;
        rr_ptr_d        = w_next_ptr;
      end
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      done_q          <= '0;
      err_q           <= '0;
      busy_q          <= 1'b0;
      fw_update_rst_q <= 1'b0;
      wait_cycles_q   <= '0;
      rr_ptr_q        <= '0;
      win_q           <= '0;
      tmo_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      done_q          <= done_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
      fw_update_rst_q <= fw_update_rst_d;
      wait_cycles_q   <= wait_cycles_d;
      rr_ptr_q        <= rr_ptr_d;
      win_q           <= win_d;
      tmo_cnt_q       <= tmo_cnt_d;
    end
  end

  assign bus.grant                     = grant_q;
  assign bus.done                      = done_q;
  assign bus.err                       = err_q;
  assign bus.busy                      = busy_q;
  assign bus.fw_update_rst             = fw_update_rst_q;
  assign bus.fw_update_rst_wait_cycles = wait_cycles_q;

endmodule
`default_nettype wire

// File: doc/soc_ifc_fw_rst_req_arb.md
Name: soc_ifc_fw_rst_req_arb

Overview:
Arbitrates firmware-update-reset requests from several requesters, for example the mailbox command handler, the uC register write and the watchdog escalation path. Delivers one request at a time to the boot sequencer, using that requester's reset-wait cycle count. Tracks the uC reset assert/release handshake and returns a per-requester done or error pulse. Sits in the noncore domain between requesters and the boot FSM's fw_update_rst / fw_update_rst_wait_cycles inputs, so it survives firmware-update resets.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
WAIT_W, 8, width of the reset-wait cycle count
TIMEOUT_CYCLES, 1024, maximum cycles allowed per service before abort (>=4)

Ports:
clk  input  1  clock
cptra_rst_b  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  level request per requester; held until that requester's done or err
req_wait_cycles  input  NUM_REQ*WAIT_W  per-requester wait count; slice i = bits [i*WAIT_W +: WAIT_W]
grant  output  NUM_REQ  one-hot; identifies the requester in service
done  output  NUM_REQ  one-cycle pulse: service completed
err  output  NUM_REQ  one-cycle pulse: service aborted on timeout
busy  output  1  high in any state other than IDLE
fw_update_rst  output  1  reset request level to the boot sequencer
fw_update_rst_wait_cycles  output  WAIT_W  latched wait count for the granted requester
fw_upd_rst_executed  input  1  pulse from the boot sequencer: reset accepted
cptra_uc_rst_b  input  1  uC reset as seen by the core, active-low

Behaviour:
- Reset values: grant=0, done=0, err=0, busy=0, fw_update_rst=0, fw_update_rst_wait_cycles=0, state=IDLE, rr_ptr=0, tmo_cnt=0. All outputs are registered.
- States: IDLE, ISSUE, WAIT_ASSERT, WAIT_RELEASE, DONE.
- IDLE:
  - Arbitration is evaluated only when |req && cptra_uc_rst_b==1.
  - Winner = first set req bit scanning upward from rr_ptr, with wrap.
  - Next cycle: state=ISSUE; grant=onehot(winner); fw_update_rst=1; wait_cycles latched from winner's slice; tmo_cnt=0.
  - Latency: req sampled at edge N produces grant and fw_update_rst at edge N+1.
- ISSUE: fw_update_rst held at 1. When fw_upd_rst_executed=1, go to WAIT_ASSERT and clear fw_update_rst on the same edge.
- WAIT_ASSERT: on cptra_uc_rst_b==0, go to WAIT_RELEASE.
- WAIT_RELEASE: on cptra_uc_rst_b==1, go to DONE.
- DONE (one cycle):
  - done[winner]=1 for exactly one cycle; grant=0.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Next state is IDLE. A re-arbitration is possible on the following cycle.
- Timeout:
  - tmo_cnt increments every cycle in ISSUE, WAIT_ASSERT and WAIT_RELEASE. It saturates and never wraps.
  - When tmo_cnt==TIMEOUT_CYCLES-1 and the state's exit condition is false: err[winner]=1 for one cycle; fw_update_rst=0; grant=0; rr_ptr advances as in DONE; state=IDLE.
  - Exit condition and timeout on the same cycle: the exit wins.
- fw_update_rst_wait_cycles keeps its value after service. It is updated only at grant.
- Request rules:
  - req deassertion after grant does not abort service; done or err is still produced.
  - req of the granted requester is ignored in DONE and in the cycle after err, which prevents a double grant on a stale level.
  - Only one of grant, done, err is nonzero per requester at any time. done and err are never simultaneous.
- Simultaneous event: fw_upd_rst_executed arriving in the same cycle as the grant is ignored; it is sampled only in ISSUE.
- Reset mid-operation: cptra_rst_b low asynchronously returns every register to its reset value. No done or err is emitted.
- Width: the tmo_cnt width is the number of bits needed to hold TIMEOUT_CYCLES. rr_ptr width is the number of bits needed to index NUM_REQ-1, minimum 1.

Test Plan:
1. Single request with req=3'b010, wait slice1=8'h20. Required:
   - grant=3'b010 and fw_update_rst=1 one cycle after req.
   - fw_upd_rst_executed pulse drops fw_update_rst; wait_cycles=8'h20.
   - uC reset low for 40 cycles then high produces done=3'b010 for one cycle, then busy=0.
2. Round-robin: req=3'b111 held, each service completed by the bench. Required grant order 001, 010, 100, 001; rr_ptr wraps.
3. Timeout: grant given, bench never pulses fw_upd_rst_executed. Required: err[winner]=1 at cycle 1024 after grant, fw_update_rst=0, state=IDLE, no done.
4. Boundary: fw_upd_rst_executed arrives exactly at tmo_cnt=1023. Required: transition to WAIT_ASSERT, no err.
5. Gated arbitration: req asserted while cptra_uc_rst_b=0. Required: no grant until cptra_uc_rst_b=1, then grant on the next cycle.
6. Reset mid-service: cptra_rst_b pulsed low in WAIT_RELEASE. Required: all outputs 0 immediately; after release, still-held req=3'b001 is granted afresh from rr_ptr=0.
